fc_layer_engine: RTL and testbench

Parametrised fully-connected layer engine for the streaming MNIST pipeline; successor to the fixed 32-input x 10-output FC stage.
- Streams N_IN activations from an upstream activation buffer and N_OUT-wide weight words from a weight buffer.
- Accumulates N_OUT signed dot products, with optional ReLU.
- Optionally computes the argmax class index.
- Presents results on a valid/ready output handshake, with backpressure, to the downstream writer or classifier.

---
 rtl/fc_pkg.sv | 20 ++
 rtl/fc_layer_engine_if.sv | 39 +++
 rtl/fc_mac_lane.sv | 35 +++
 rtl/fc_layer_engine.sv | 153 +++++++++++++++
 tb/tb_fc_layer_engine.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        ARGMAX,
        HOLD
    } fc_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fc_layer_engine_if.sv
// Buffer read ports plus the result valid/ready handshake of the FC engine.
interface fc_layer_engine_if
    import fc_pkg::*;
#(
    parameter int unsigned N_IN   = 32,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned IN_W   = 8,
    parameter int unsigned W_W    = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = clog2(N_IN),
    parameter int unsigned IDX_W  = clog2(N_OUT)
) ();

    logic [ADDR_W-1:0]      x_addr_o;
    logic                   x_en_o;
    logic [IN_W-1:0]        x_data_i;
    logic [ADDR_W-1:0]      w_addr_o;
    logic                   w_en_o;
    logic [N_OUT*W_W-1:0]   w_data_i;
    logic [N_OUT*ACC_W-1:0] data_o;
    logic [IDX_W-1:0]       idx_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   busy_o;
    logic                   done_o;

    modport master (
        output x_addr_o, x_en_o, w_addr_o, w_en_o,
        output data_o, idx_o, valid_o, busy_o, done_o,
        input  x_data_i, w_data_i, ready_i
    );

    modport slave (
        input  x_addr_o, x_en_o, w_addr_o, w_en_o,
        input  data_o, idx_o, valid_o, busy_o, done_o,
        output x_data_i, w_data_i, ready_i
    );

endinterface

// File: rtl/fc_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear and wrapping add.
module fc_mac_lane #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned W_W   = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [IN_W-1:0]  x,
    input  logic [W_W-1:0]   w,
    output logic [ACC_W-1:0] acc_nxt
);

    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc;

    // Product formed at accumulator width; exact because ACC_W >= IN_W+W_W.
    always_comb begin
        prod    = ACC_W'($signed(x)) * ACC_W'($signed(w));
        acc_nxt = en ? acc + prod : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: streams N_IN activations/weight words, accumulates
// N_OUT dot products, optional ReLU and argmax, then holds on valid/ready.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int unsigned N_IN      = 32,
    parameter int unsigned N_OUT     = 10,
    parameter int unsigned IN_W      = 8,
    parameter int unsigned W_W       = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned ADDR_W    = clog2(N_IN),
    parameter bit          RELU_EN   = 1'b0,
    parameter bit          ARGMAX_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    fc_layer_engine_if.master bus
);

    localparam int unsigned IDX_W = clog2(N_OUT);

    fc_state_t               state;
    logic [ADDR_W-1:0]       cnt;
    logic [IDX_W-1:0]        lane_cnt;
    logic [IDX_W-1:0]        best_idx;
    logic [IDX_W-1:0]        idx_r;
    logic                    x_en;
    logic                    en_d;
    logic                    valid_r;
    logic                    clr;
    logic [N_OUT*ACC_W-1:0]  acc_nxt;
    logic [N_OUT*ACC_W-1:0]  relu_res;
    logic [N_OUT*ACC_W-1:0]  data_r;
    logic signed [ACC_W-1:0] lanes_q [N_OUT];
    logic signed [ACC_W-1:0] best_val;
    logic signed [ACC_W-1:0] cur;
    logic                    greater;
    logic                    last_lane;

    genvar j;
    generate
        for (j = 0; j < N_OUT; j++) begin : g_lane
            fc_mac_lane #(
                .IN_W (IN_W),
                .W_W  (W_W),
                .ACC_W(ACC_W)
            ) u_lane (
                .clk    (clk_i),
                .rst_n  (rstn_i),
                .clr    (clr),
                .en     (en_d),
                .x      (bus.x_data_i),
                .w      (bus.w_data_i[j*W_W +: W_W]),
                .acc_nxt(acc_nxt[j*ACC_W +: ACC_W])
            );
        end
    endgenerate

    // Results come from acc_nxt so the product landing in DRAIN is included.
    always_comb begin
        clr      = (state == IDLE) && start_i;
        relu_res = acc_nxt;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (RELU_EN && acc_nxt[k*ACC_W + ACC_W - 1]) begin
                relu_res[k*ACC_W +: ACC_W] = '0;
            end
        end
        for (int unsigned k = 0; k < N_OUT; k++) begin
            lanes_q[k] = data_r[k*ACC_W +: ACC_W];
        end
        cur       = lanes_q[lane_cnt];
        greater   = cur > best_val;
        last_lane = (lane_cnt == IDX_W'(N_OUT - 1));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            cnt      <= '0;
            lane_cnt <= '0;
            best_idx <= '0;
            best_val <= '0;
            idx_r    <= '0;
            x_en     <= 1'b0;
            en_d     <= 1'b0;
            valid_r  <= 1'b0;
            data_r   <= '0;
        end else begin
            en_d <= x_en;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cnt   <= '0;
                        x_en  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (cnt == ADDR_W'(N_IN - 1)) begin
                        x_en  <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    data_r   <= relu_res;
                    best_val <= relu_res[ACC_W-1:0];
                    best_idx <= '0;
                    lane_cnt <= '0;
                    if (ARGMAX_EN) begin
                        state <= ARGMAX;
                    end else begin
                        valid_r <= 1'b1;
                        state   <= HOLD;
                    end
                end
                ARGMAX: begin
                    if (greater) begin
                        best_val <= cur;
                        best_idx <= lane_cnt;
                    end
                    if (last_lane) begin
                        idx_r   <= greater ? lane_cnt : best_idx;
                        valid_r <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        lane_cnt <= lane_cnt + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.ready_i) begin
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x_addr_o = cnt;
    assign bus.w_addr_o = cnt;
    assign bus.x_en_o   = x_en;
    assign bus.w_en_o   = x_en;
    assign bus.data_o   = data_r;
    assign bus.idx_o    = idx_r;
    assign bus.valid_o  = valid_r;
    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = valid_r && bus.ready_i;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: three configurations against a plain-arithmetic model.
module tb_fc_layer_engine;

    localparam int N_IN  = 32;
    localparam int N_OUT = 10;

    typedef struct {
        int     dut;
        int     pat;
        int     hold;
        bit     poke;
        bit     fixed;
        int     exp_lat;
        int     exp_idx;
        longint exp_l0;
        longint exp_l3;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] ready = '0;

    logic signed [7:0]      xm [N_IN];
    logic [N_OUT*8-1:0]     wm [N_IN];

    int n_tests = 0;
    int n_fail  = 0;

    longint exp_lane [N_OUT];
    int     exp_idx;

    fc_layer_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(8), .W_W(8), .ACC_W(32)) bus0 ();
    fc_layer_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(8), .W_W(8), .ACC_W(16)) bus1 ();
    fc_layer_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(8), .W_W(8), .ACC_W(32)) bus2 ();

    fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(8), .W_W(8), .ACC_W(32),
                      .RELU_EN(0), .ARGMAX_EN(1))
        u_dut0 (.clk_i(clk), .rstn_i(rst_n), .start_i(start[0]), .bus(bus0));
    fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(8), .W_W(8), .ACC_W(16),
                      .RELU_EN(0), .ARGMAX_EN(1))
        u_dut1 (.clk_i(clk), .rstn_i(rst_n), .start_i(start[1]), .bus(bus1));
    fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(8), .W_W(8), .ACC_W(32),
                      .RELU_EN(1), .ARGMAX_EN(0))
        u_dut2 (.clk_i(clk), .rstn_i(rst_n), .start_i(start[2]), .bus(bus2));

    assign bus0.ready_i = ready[0];
    assign bus1.ready_i = ready[1];
    assign bus2.ready_i = ready[2];

    always #5 clk = ~clk;

    // Registered-read buffer models, one read port per engine
    always @(posedge clk) begin
        if (bus0.x_en_o) bus0.x_data_i <= xm[bus0.x_addr_o];
        if (bus0.w_en_o) bus0.w_data_i <= wm[bus0.w_addr_o];
        if (bus1.x_en_o) bus1.x_data_i <= xm[bus1.x_addr_o];
        if (bus1.w_en_o) bus1.w_data_i <= wm[bus1.w_addr_o];
        if (bus2.x_en_o) bus2.x_data_i <= xm[bus2.x_addr_o];
        if (bus2.w_en_o) bus2.w_data_i <= wm[bus2.w_addr_o];
    end

    logic [2:0] valid, busy, done, xen, wen;
    logic [4:0] xaddr [3];
    logic [4:0] waddr [3];
    logic [3:0] idx   [3];
    longint     got   [3][N_OUT];

    always_comb begin
        valid    = {bus2.valid_o, bus1.valid_o, bus0.valid_o};
        busy     = {bus2.busy_o,  bus1.busy_o,  bus0.busy_o};
        done     = {bus2.done_o,  bus1.done_o,  bus0.done_o};
        xen      = {bus2.x_en_o,  bus1.x_en_o,  bus0.x_en_o};
        wen      = {bus2.w_en_o,  bus1.w_en_o,  bus0.w_en_o};
        xaddr[0] = bus0.x_addr_o;
        xaddr[1] = bus1.x_addr_o;
        xaddr[2] = bus2.x_addr_o;
        waddr[0] = bus0.w_addr_o;
        waddr[1] = bus1.w_addr_o;
        waddr[2] = bus2.w_addr_o;
        idx[0]   = bus0.idx_o;
        idx[1]   = bus1.idx_o;
        idx[2]   = bus2.idx_o;
        for (int j = 0; j < N_OUT; j++) begin
            got[0][j] = longint'($signed(bus0.data_o[j*32 +: 32]));
            got[1][j] = longint'($signed(bus1.data_o[j*16 +: 16]));
            got[2][j] = longint'($signed(bus2.data_o[j*32 +: 32]));
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Dot products from the buffer contents, wrapped to acc_w, then ReLU/argmax
    task automatic model(input int acc_w, input bit relu, input bit am);
        longint     sum, m, full;
        logic [7:0] wb;
        full = longint'(1) << acc_w;
        for (int j = 0; j < N_OUT; j++) begin
            sum = 0;
            for (int i = 0; i < N_IN; i++) begin
                wb  = wm[i][j*8 +: 8];
                sum += longint'(xm[i]) * longint'($signed(wb));
            end
            m = sum % full;
            if (m < 0) m += full;
            if (m >= full / 2) m -= full;
            if (relu && m < 0) m = 0;
            exp_lane[j] = m;
        end
        exp_idx = 0;
        if (am) begin
            for (int j = 1; j < N_OUT; j++) begin
                if (exp_lane[j] > exp_lane[exp_idx]) exp_idx = j;
            end
        end
    endtask

    task automatic load(input int pat);
        int wv;
        for (int i = 0; i < N_IN; i++) begin
            case (pat)
                0:       xm[i] = 8'sd1;
                1:       xm[i] = -8'sd1;
                2:       xm[i] = (i == 0) ? 8'sd10 : 8'sd0;
                3:       xm[i] = 8'sd127;
                default: xm[i] = 8'($urandom);
            endcase
            for (int j = 0; j < N_OUT; j++) begin
                case (pat)
                    0:       wv = j + 1;
                    1:       wv = (j == 3) ? 1 : -1;
                    2:       wv = (i != 0) ? int'($urandom_range(0, 255)) :
                                  ((j == 2 || j == 7) ? 10 : j);
                    3:       wv = 127;
                    default: wv = int'($urandom);
                endcase
                wm[i][j*8 +: 8] = 8'(wv);
            end
        end
    endtask

    task automatic run_case(input vec_t vc, input string tag);
        int     d;
        int     lat;
        bit     addr_ok;
        bit     stable;
        longint snap [N_OUT];
        d       = vc.dut;
        addr_ok = 1'b1;
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        lat = 0;
        while (!valid[d] && lat < 200) begin
            if (lat <= N_IN) begin
                if (xen[d] !== (lat < N_IN)) addr_ok = 1'b0;
                if (xaddr[d] != 5'((lat < N_IN) ? lat : N_IN - 1)) addr_ok = 1'b0;
            end
            if (wen[d] !== xen[d] || waddr[d] !== xaddr[d]) addr_ok = 1'b0;
            start[d] = vc.poke && (lat == 5);
            @(negedge clk);
            lat++;
        end
        start[d] = 1'b0;
        check({tag, "_latency"}, lat, vc.exp_lat);
        check({tag, "_fetch_addr"}, addr_ok, 1);
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s_lane%0d", tag, j), got[d][j], exp_lane[j]);
        end
        check({tag, "_idx"}, idx[d], exp_idx);
        if (vc.fixed) begin
            check({tag, "_idx_const"}, idx[d], vc.exp_idx);
            check({tag, "_lane0_const"}, got[d][0], vc.exp_l0);
            check({tag, "_lane3_const"}, got[d][3], vc.exp_l3);
        end
        for (int j = 0; j < N_OUT; j++) snap[j] = got[d][j];
        stable = 1'b1;
        for (int h = 0; h < vc.hold; h++) begin
            @(negedge clk);
            if (!valid[d] || done[d]) stable = 1'b0;
            for (int j = 0; j < N_OUT; j++) if (got[d][j] != snap[j]) stable = 1'b0;
        end
        check({tag, "_hold_stable"}, stable, 1);
        ready[d] = 1'b1;
        start[d] = vc.poke;
        #1;
        check({tag, "_done_pulse"}, done[d], 1);
        @(negedge clk);
        ready[d] = 1'b0;
        start[d] = 1'b0;
        check({tag, "_after_accept"}, {valid[d], done[d], busy[d]}, 0);
        @(negedge clk);
        check({tag, "_start_dropped"}, busy[d], 0);
        stable = 1'b1;
        for (int j = 0; j < N_OUT; j++) if (got[d][j] != snap[j]) stable = 1'b0;
        check({tag, "_data_retained"}, stable, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        vec_t vpost;
        int   n;
        bit   zero;

        // dut 1 has 16-bit accumulators: 127*127*32 = 516128 wraps to -8160
        vecs[0] = '{0, 0, 0, 1'b0, 1'b1, 43, 9, 32, 128};
        vecs[1] = '{2, 1, 0, 1'b0, 1'b1, 33, 0, 32, 0};
        vecs[2] = '{0, 2, 2, 1'b0, 1'b1, 43, 2, 0, 30};
        vecs[3] = '{1, 3, 5, 1'b1, 1'b1, 43, 0, -8160, -8160};
        vecs[4] = '{0, 4, 5, 1'b1, 1'b0, 43, 0, 0, 0};
        vecs[5] = '{1, 4, 1, 1'b0, 1'b0, 43, 0, 0, 0};
        vecs[6] = '{2, 4, 3, 1'b1, 1'b0, 33, 0, 0, 0};
        vecs[7] = '{0, 4, 0, 1'b0, 1'b0, 43, 0, 0, 0};
        vpost   = '{0, 4, 1, 1'b0, 1'b0, 43, 0, 0, 0};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ctrl%0d", d), {valid[d], busy[d], done[d], xen[d], wen[d]}, 0);
            check($sformatf("reset_addr%0d", d), {xaddr[d], waddr[d], idx[d]}, 0);
            zero = 1'b1;
            for (int j = 0; j < N_OUT; j++) if (got[d][j] != 0) zero = 1'b0;
            check($sformatf("reset_data%0d", d), zero, 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            load(vecs[v].pat);
            model((vecs[v].dut == 1) ? 16 : 32, vecs[v].dut == 2, vecs[v].dut != 2);
            run_case(vecs[v], $sformatf("v%0d", v));
        end

        // Abort mid-FETCH, then rerun the same image with no residue allowed
        load(4);
        model(32, 1'b0, 1'b1);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (!(xen[0] && xaddr[0] == 5'd10) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_addr10", xaddr[0], 10);
        rst_n = 1'b0;
        #1;
        check("rst_abort_ctrl", {valid[0], busy[0], done[0], xen[0], wen[0]}, 0);
        check("rst_abort_addr", {xaddr[0], idx[0]}, 0);
        zero = 1'b1;
        for (int j = 0; j < N_OUT; j++) if (got[0][j] != 0) zero = 1'b0;
        check("rst_abort_data", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_case(vpost, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
